// File: rtl/rs232_pkg.sv
// Shared types and helpers for the RS-232 transmit path: FSM states,
// parity mode encodings and the fractional baud increment calculation.
package rs232_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2
  } tx_state_t;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;
  localparam logic [1:0] PAR_MARK = 2'b11;

  // Rounded increment for a phase accumulator that overflows once per bit period.
  function automatic int baud_inc(input longint clock_freq, input longint baud_rate,
                                  input int acc_width);
    longint num;
    longint den;
    num = (baud_rate << (acc_width - 4)) + (clock_freq >> 5);
    den = clock_freq >> 4;
    return int'(num / den);
  endfunction

endpackage

// File: rtl/rs232_tx_fifo.sv
// Small show-ahead character FIFO feeding the framer; a write into a full
// FIFO is dropped and flagged with a one-cycle overflow pulse.
module rs232_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int AW    = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count,
  output logic             overflow
);

  localparam int DEPTH = 2 ** AW;
  localparam logic [AW:0] FULL_COUNT = {1'b1, {AW{1'b0}}};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             overflow_reg;
  logic             do_push;
  logic             do_pop;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == FULL_COUNT);

  // A pop in the same cycle frees the slot, so a write into a full FIFO still lands.
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && (!full || do_pop) && !flush;

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  assign rd_data = mem[rd_ptr_reg];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else if (flush) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      overflow_reg <= push && !do_push;
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign count    = count_reg;
  assign overflow = overflow_reg;

endmodule

// File: rtl/rs232_tx_framer.sv
// RS-232 transmitter: FIFO-buffered characters framed with configurable
// parity and stop bits, paced by a fractional baud accumulator.
module rs232_tx_framer
  import rs232_pkg::*;
#(
  parameter int CLOCK_FREQ     = 100000000,
  parameter int BAUD_RATE      = 115200,
  parameter int BAUD_ACC_WIDTH = 16,
  parameter int DATA_BITS      = 8,
  parameter int FIFO_AW        = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 abort,
  input  logic                 tx_datain_ready,
  input  logic [DATA_BITS-1:0] tx_datain,
  input  logic [1:0]           cfg_parity,
  input  logic                 cfg_two_stop,
  output logic                 tx_fifo_full,
  output logic [FIFO_AW:0]     tx_fifo_count,
  output logic                 tx_overflow,
  output logic                 tx_transmitter,
  output logic                 tx_transmitter_valid
);

  localparam int INC_INT = baud_inc(CLOCK_FREQ, BAUD_RATE, BAUD_ACC_WIDTH);
  localparam logic [BAUD_ACC_WIDTH:0] INC = INC_INT[BAUD_ACC_WIDTH:0];
  localparam int CW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS - 1);

  tx_state_t               state_reg;
  logic [BAUD_ACC_WIDTH:0] acc_reg;
  logic [DATA_BITS-1:0]    shift_reg;
  logic [CW-1:0]           bit_cnt_reg;
  logic [1:0]              parity_mode_reg;
  logic                    two_stop_reg;
  logic                    parity_bit_reg;
  logic                    line_reg;

  logic                    baud_tick;
  logic                    frame_load;
  logic                    load_parity;
  logic [DATA_BITS-1:0]    head_data;
  logic                    fifo_empty;

  rs232_tx_fifo #(
    .WIDTH (DATA_BITS),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .flush    (abort),
    .push     (tx_datain_ready),
    .wr_data  (tx_datain),
    .pop      (frame_load),
    .rd_data  (head_data),
    .full     (tx_fifo_full),
    .empty    (fifo_empty),
    .count    (tx_fifo_count),
    .overflow (tx_overflow)
  );

  assign baud_tick = acc_reg[BAUD_ACC_WIDTH];

  // A new frame starts from IDLE at once, or straight out of the last stop bit.
  always_comb begin
    frame_load = 1'b0;
    if (!abort && !fifo_empty) begin
      case (state_reg)
        IDLE:    frame_load = 1'b1;
        STOP1:   frame_load = baud_tick && !two_stop_reg;
        STOP2:   frame_load = baud_tick;
        default: frame_load = 1'b0;
      endcase
    end
  end

  always_comb begin
    case (cfg_parity)
      PAR_EVEN: load_parity = ^head_data;
      PAR_ODD:  load_parity = ~^head_data;
      PAR_MARK: load_parity = 1'b1;
      default:  load_parity = 1'b0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      acc_reg         <= '0;
      shift_reg       <= '1;
      bit_cnt_reg     <= '0;
      parity_mode_reg <= PAR_NONE;
      two_stop_reg    <= 1'b0;
      parity_bit_reg  <= 1'b0;
      line_reg        <= 1'b1;
    end else if (abort) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      shift_reg <= '1;
      line_reg  <= 1'b1;
    end else begin
      case (state_reg)
        START:   line_reg <= 1'b0;
        DATA:    line_reg <= shift_reg[0];
        PARITY:  line_reg <= parity_bit_reg;
        default: line_reg <= 1'b1;
      endcase

      // The accumulator runs from the load edge so the start bit lasts a full period.
      acc_reg <= {1'b0, acc_reg[BAUD_ACC_WIDTH-1:0]} + INC;

      if (frame_load) begin
        state_reg       <= START;
        shift_reg       <= head_data;
        bit_cnt_reg     <= '0;
        parity_mode_reg <= cfg_parity;
        two_stop_reg    <= cfg_two_stop;
        parity_bit_reg  <= load_parity;
      end else begin
        case (state_reg)
          IDLE: begin
            acc_reg <= '0;
          end
          START: begin
            if (baud_tick) state_reg <= DATA;
          end
          DATA: begin
            if (baud_tick) begin
              shift_reg   <= {1'b1, shift_reg[DATA_BITS-1:1]};
              bit_cnt_reg <= bit_cnt_reg + 1'b1;
              if (bit_cnt_reg == LAST_BIT) begin
                state_reg <= (parity_mode_reg != PAR_NONE) ? PARITY : STOP1;
              end
            end
          end
          PARITY: begin
            if (baud_tick) state_reg <= STOP1;
          end
          STOP1: begin
            if (baud_tick) begin
              if (two_stop_reg) begin
                state_reg <= STOP2;
              end else begin
                state_reg <= IDLE;
                acc_reg   <= '0;
              end
            end
          end
          STOP2: begin
            if (baud_tick) begin
              state_reg <= IDLE;
              acc_reg   <= '0;
            end
          end
          default: begin
            state_reg <= IDLE;
            acc_reg   <= '0;
          end
        endcase
      end
    end
  end

  assign tx_transmitter       = line_reg;
  assign tx_transmitter_valid = (state_reg != IDLE);

endmodule

// File: tb/tb_rs232_tx_framer.sv
// Scoreboard bench: stimulus queues expected frames, a line monitor per DUT
// decodes the serial output and compares against the queue head.
module tb_rs232_tx_framer;

  typedef struct {
    logic [8:0] data;
    int         nbits;
    bit         par_en;
    bit         par_bit;
    bit         two_stop;
    bit         skip;
  } frame_t;

  logic       clock;
  logic       reset;
  logic       abort;
  logic [1:0] cfg_parity;
  logic       cfg_two_stop;

  logic       rdy8;
  logic [7:0] din8;
  logic       full8;
  logic [2:0] count8;
  logic       ovf8;
  logic       line8;
  logic       valid8;

  logic       rdy5;
  logic [4:0] din5;
  logic       full5;
  logic [2:0] count5;
  logic       ovf5;
  logic       line5;
  logic       valid5;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  frame_t exp8_q[$];
  frame_t exp5_q[$];
  int     starts8[$];

  rs232_tx_framer #(
    .CLOCK_FREQ(1600000), .BAUD_RATE(100000), .BAUD_ACC_WIDTH(16), .DATA_BITS(8), .FIFO_AW(2)
  ) dut8 (
    .clock(clock), .reset(reset), .abort(abort),
    .tx_datain_ready(rdy8), .tx_datain(din8),
    .cfg_parity(cfg_parity), .cfg_two_stop(cfg_two_stop),
    .tx_fifo_full(full8), .tx_fifo_count(count8), .tx_overflow(ovf8),
    .tx_transmitter(line8), .tx_transmitter_valid(valid8)
  );

  rs232_tx_framer #(
    .CLOCK_FREQ(1600000), .BAUD_RATE(100000), .BAUD_ACC_WIDTH(16), .DATA_BITS(5), .FIFO_AW(2)
  ) dut5 (
    .clock(clock), .reset(reset), .abort(abort),
    .tx_datain_ready(rdy5), .tx_datain(din5),
    .cfg_parity(cfg_parity), .cfg_two_stop(cfg_two_stop),
    .tx_fifo_full(full5), .tx_fifo_count(count5), .tx_overflow(ovf5),
    .tx_transmitter(line5), .tx_transmitter_valid(valid5)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic line_of(input bit sel);
    return sel ? line5 : line8;
  endfunction

  function automatic logic valid_of(input bit sel);
    return sel ? valid5 : valid8;
  endfunction

  function automatic logic [31:0] count_of(input bit sel);
    return sel ? {29'd0, count5} : {29'd0, count8};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic monitor(input bit sel);
    frame_t     f;
    logic [8:0] got;
    forever begin
      @(negedge clock);
      if (line_of(sel) === 1'b0) begin
        if (sel == 1'b0) starts8.push_back(cyc);
        if ((sel ? exp5_q.size() : exp8_q.size()) == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_frame: dut%0d line low with no frame expected (cycle %0d)",
                   sel ? 5 : 8, cyc);
          repeat (200) @(negedge clock);
        end else begin
          if (sel) f = exp5_q.pop_front();
          else     f = exp8_q.pop_front();
          repeat (8) @(negedge clock);
          if (!f.skip) check(sel ? "dut5_start_bit" : "dut8_start_bit", line_of(sel), 0);
          got = '0;
          for (int i = 0; i < f.nbits; i++) begin
            repeat (16) @(negedge clock);
            got[i] = line_of(sel);
          end
          if (!f.skip) check(sel ? "dut5_data_bits" : "dut8_data_bits", got, f.data);
          if (f.par_en) begin
            repeat (16) @(negedge clock);
            if (!f.skip) check(sel ? "dut5_parity_bit" : "dut8_parity_bit", line_of(sel), f.par_bit);
          end
          repeat (16) @(negedge clock);
          if (!f.skip) check(sel ? "dut5_stop1" : "dut8_stop1", line_of(sel), 1);
          if (f.two_stop) begin
            repeat (16) @(negedge clock);
            if (!f.skip) check(sel ? "dut5_stop2" : "dut8_stop2", line_of(sel), 1);
          end
          $display("dut%0d frame data=%03h parity_en=%0d stops=%0d skipped=%0d",
                   sel ? 5 : 8, got, f.par_en, f.two_stop ? 2 : 1, f.skip);
        end
      end
    end
  endtask

  initial monitor(1'b0);
  initial monitor(1'b1);

  task automatic push_exp(input bit sel, input logic [8:0] d, input bit par_en, input bit pbit,
                          input bit two, input bit skip);
    frame_t f;
    f.data = d; f.nbits = sel ? 5 : 8; f.par_en = par_en; f.par_bit = pbit;
    f.two_stop = two; f.skip = skip;
    if (sel) exp5_q.push_back(f);
    else     exp8_q.push_back(f);
  endtask

  // Single write into an idle DUT, checking load latency and total frame length.
  task automatic send_one(input bit sel, input logic [8:0] data, input logic [1:0] par,
                          input bit two, input int exp_len, input bit scramble,
                          input logic [8:0] exp_data, input bit exp_pbit);
    int n;
    push_exp(sel, exp_data, par != 2'b00, exp_pbit, two, 1'b0);
    @(negedge clock);
    cfg_parity = par;
    cfg_two_stop = two;
    if (sel) begin din5 = data[4:0]; rdy5 = 1'b1; end
    else     begin din8 = data[7:0]; rdy8 = 1'b1; end
    @(negedge clock);
    rdy5 = 1'b0;
    rdy8 = 1'b0;
    check("count_after_write", count_of(sel), 1);
    check("valid_before_load", valid_of(sel), 0);
    @(negedge clock);
    check("valid_after_load", valid_of(sel), 1);
    check("line_high_at_load", line_of(sel), 1);
    check("count_after_pop", count_of(sel), 0);
    @(negedge clock);
    check("line_low_after_e2", line_of(sel), 0);
    n = 1;
    while (valid_of(sel) && n < 3000) begin
      if (scramble && n == 40) begin
        cfg_parity = 2'b00;
        cfg_two_stop = 1'b0;
      end
      @(negedge clock);
      n++;
    end
    check("frame_length", n, exp_len);
    repeat (20) @(negedge clock);
  endtask

  initial begin
    repeat (20000) @(posedge clock);
    $display("FAIL timeout: simulation exceeded cycle budget");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int b;
    int exp_cnt[6];
    exp_cnt = '{1, 1, 2, 3, 4, 4};

    reset = 1'b1; abort = 1'b0; cfg_parity = 2'b00; cfg_two_stop = 1'b0;
    rdy8 = 1'b0; din8 = '0; rdy5 = 1'b0; din5 = '0;
    repeat (3) @(negedge clock);
    check("reset_line", line8, 1);
    check("reset_valid", valid8, 0);
    check("reset_count", count8, 0);
    check("reset_full", full8, 0);
    check("reset_overflow", ovf8, 0);
    check("reset_line5", line5, 1);
    reset = 1'b0;
    repeat (3) @(negedge clock);

    // 8N1, then parity/stop variants; the odd case changes cfg mid-frame.
    send_one(1'b0, 9'h0A5, 2'b00, 1'b0, 160, 1'b0, 9'h0A5, 1'b0);
    send_one(1'b0, 9'h007, 2'b01, 1'b1, 192, 1'b0, 9'h007, 1'b1);
    send_one(1'b0, 9'h007, 2'b10, 1'b1, 192, 1'b1, 9'h007, 1'b0);
    send_one(1'b0, 9'h007, 2'b11, 1'b1, 192, 1'b0, 9'h007, 1'b1);

    // Back-to-back characters must produce contiguous frames.
    cfg_parity = 2'b00; cfg_two_stop = 1'b0;
    b = starts8.size();
    push_exp(1'b0, 9'h011, 1'b0, 1'b0, 1'b0, 1'b0);
    push_exp(1'b0, 9'h022, 1'b0, 1'b0, 1'b0, 1'b0);
    push_exp(1'b0, 9'h033, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clock); din8 = 8'h11; rdy8 = 1'b1;
    @(negedge clock); din8 = 8'h22;
    @(negedge clock); din8 = 8'h33;
    check("b2b_valid_after_load", valid8, 1);
    @(negedge clock); rdy8 = 1'b0;
    n = 1;
    while (valid8 && n < 3000) begin
      @(negedge clock);
      n++;
    end
    check("b2b_total_length", n, 480);
    repeat (20) @(negedge clock);
    if (starts8.size() >= b + 3) begin
      check("b2b_gap_1_2", starts8[b+1] - starts8[b], 160);
      check("b2b_gap_2_3", starts8[b+2] - starts8[b+1], 160);
    end else begin
      check("b2b_frame_starts", starts8.size() - b, 3);
    end

    // Overflow: six writes while idle, the sixth is dropped.
    for (int i = 0; i < 5; i++) push_exp(1'b0, 9'(i + 1), 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clock); din8 = 8'h01; rdy8 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      check("ovf_count_seq", count8, exp_cnt[i]);
      check("ovf_pulse_seq", ovf8, (i == 5) ? 1 : 0);
      if (i < 5) din8 = 8'(i + 2);
      else       rdy8 = 1'b0;
    end
    check("ovf_full", full8, 1);
    @(negedge clock);
    check("ovf_pulse_cleared", ovf8, 0);
    n = 0;
    while (valid8 && n < 3000) begin
      @(negedge clock);
      n++;
    end
    check("ovf_drained_count", count8, 0);
    repeat (20) @(negedge clock);

    // Abort mid-DATA with three characters queued behind the active one.
    push_exp(1'b0, 9'h040, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clock); din8 = 8'h40; rdy8 = 1'b1;
    @(negedge clock); din8 = 8'h41;
    @(negedge clock); din8 = 8'h42;
    @(negedge clock); din8 = 8'h43;
    @(negedge clock); rdy8 = 1'b0;
    check("abort_queued_count", count8, 3);
    repeat (58) @(negedge clock);
    check("abort_line_before", line8, 0);
    abort = 1'b1; din8 = 8'h55; rdy8 = 1'b1;
    @(negedge clock);
    abort = 1'b0; rdy8 = 1'b0;
    check("abort_line", line8, 1);
    check("abort_count", count8, 0);
    check("abort_valid", valid8, 0);
    check("abort_overflow", ovf8, 0);
    check("abort_full", full8, 0);
    @(negedge clock);
    check("abort_write_ignored", valid8, 0);
    repeat (300) @(negedge clock);

    // Five-bit characters: upper input bits never reach the line.
    send_one(1'b1, 9'h0FF, 2'b00, 1'b0, 112, 1'b0, 9'h01F, 1'b0);
    send_one(1'b1, 9'h016, 2'b01, 1'b0, 128, 1'b0, 9'h016, 1'b1);

    repeat (50) @(negedge clock);
    check("dut8_queue_drained", exp8_q.size(), 0);
    check("dut5_queue_drained", exp5_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
